// File: rtl/fir_stream_filter.sv
// Multi-channel streaming FIR with loadable coefficients and one sequential MAC.
// Ports: clk, rst (async, active-high); in_valid/in_ready/in_ch/x_in carry samples in;
// out_valid/out_ready/out_ch/y_out/y_sat carry rounded, saturated results out;
// coef_we/coef_addr/coef_data load taps; err pulses on dropped work; busy = not idle.
module fir_stream_filter #(
  parameter int WIDTH      = 16,
  parameter int OUT_WIDTH  = WIDTH + 4,
  parameter int COEF_WIDTH = 16,
  parameter int TAPS       = 8,
  parameter int CHANNELS   = 2,
  parameter int SHIFT      = 15,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int AW = (TAPS > 1) ? $clog2(TAPS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CW-1:0]         in_ch,
  input  logic [WIDTH-1:0]      x_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CW-1:0]         out_ch,
  output logic [OUT_WIDTH-1:0]  y_out,
  output logic                  y_sat,
  input  logic                  coef_we,
  input  logic [AW-1:0]         coef_addr,
  input  logic [COEF_WIDTH-1:0] coef_data,
  output logic                  err,
  output logic                  busy
);

  localparam int PW    = WIDTH + COEF_WIDTH;
  localparam int ACC_W = PW + $clog2(TAPS);
  localparam int SW    = ACC_W + OUT_WIDTH + 1;
  localparam int DEF_I = (1 << SHIFT) / TAPS;

  localparam logic signed [COEF_WIDTH-1:0] DEF_C = DEF_I[COEF_WIDTH-1:0];
  localparam logic [CW:0] NCH = CHANNELS[CW:0];
  localparam logic [AW:0] NTP = TAPS[AW:0];
  localparam logic [AW-1:0] KLAST = AW'(TAPS - 1);

  localparam logic signed [SW-1:0] RND =
    {{(SW-1){1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [SW-1:0] OMAX =
    {{(SW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] OMIN =
    {{(SW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, ROUND, HOLD} state_t;

  state_t state_q, state_d;

  logic signed [WIDTH-1:0]      h_q [CHANNELS][TAPS];
  logic signed [WIDTH-1:0]      h_d [CHANNELS][TAPS];
  logic signed [COEF_WIDTH-1:0] coef_q [TAPS];
  logic signed [COEF_WIDTH-1:0] coef_d [TAPS];

  logic signed [ACC_W-1:0]     acc_q, acc_d;
  logic [AW-1:0]               k_q, k_d;
  logic [CW-1:0]               ch_q, ch_d;
  logic [OUT_WIDTH-1:0]        y_q, y_d;
  logic                        sat_q, sat_d;
  logic [CW-1:0]               och_q, och_d;
  logic                        ov_q, ov_d;
  logic                        err_q, err_d;
  logic                        busy_q, busy_d;

  logic signed [PW-1:0]        prod;
  logic signed [SW-1:0]        ext;
  logic signed [SW-1:0]        shr;
  logic                        ch_ok;
  logic                        addr_ok;

  assign ch_ok   = {1'b0, in_ch} < NCH;
  assign addr_ok = {1'b0, coef_addr} < NTP;

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    coef_d  = coef_q;
    acc_d   = acc_q;
    k_d     = k_q;
    ch_d    = ch_q;
    y_d     = y_q;
    sat_d   = sat_q;
    och_d   = och_q;
    ov_d    = ov_q;
    err_d   = 1'b0;

    prod = coef_q[k_q] * h_q[ch_q][k_q];
    ext  = {{(SW-ACC_W){acc_q[ACC_W-1]}}, acc_q};
    // round half up, then arithmetic shift (floor)
    shr  = (ext + RND) >>> SHIFT;

    // coefficient load is only legal between samples
    if (coef_we) begin
      if (state_q == IDLE && addr_ok) begin
        for (int t = 0; t < TAPS; t++) begin
          if (coef_addr == AW'(t)) coef_d[t] = coef_data;
        end
      end else begin
        err_d = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (ch_ok) begin
            for (int c = 0; c < CHANNELS; c++) begin
              if (in_ch == CW'(c)) begin
                h_d[c][0] = x_in;
                for (int t = 1; t < TAPS; t++) begin
                  h_d[c][t] = h_q[c][t-1];
                end
              end
            end
            ch_d    = in_ch;
            acc_d   = '0;
            k_d     = '0;
            state_d = MAC;
          end else begin
            // consumed but discarded
            err_d = 1'b1;
          end
        end
      end
      MAC: begin
        acc_d = acc_q + {{(ACC_W-PW){prod[PW-1]}}, prod};
        k_d   = k_q + AW'(1);
        if (k_q == KLAST) state_d = ROUND;
      end
      ROUND: begin
        if (shr > OMAX) begin
          y_d   = OMAX[OUT_WIDTH-1:0];
          sat_d = 1'b1;
        end else if (shr < OMIN) begin
          y_d   = OMIN[OUT_WIDTH-1:0];
          sat_d = 1'b1;
        end else begin
          y_d   = shr[OUT_WIDTH-1:0];
          sat_d = 1'b0;
        end
        och_d   = ch_q;
        ov_d    = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      for (int c = 0; c < CHANNELS; c++) begin
        for (int t = 0; t < TAPS; t++) begin
          h_q[c][t] <= '0;
        end
      end
      for (int t = 0; t < TAPS; t++) begin
        coef_q[t] <= DEF_C;
      end
      acc_q  <= '0;
      k_q    <= '0;
      ch_q   <= '0;
      y_q    <= '0;
      sat_q  <= 1'b0;
      och_q  <= '0;
      ov_q   <= 1'b0;
      err_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      coef_q  <= coef_d;
      acc_q   <= acc_d;
      k_q     <= k_d;
      ch_q    <= ch_d;
      y_q     <= y_d;
      sat_q   <= sat_d;
      och_q   <= och_d;
      ov_q    <= ov_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = ov_q;
  assign out_ch    = och_q;
  assign y_out     = y_q;
  assign y_sat     = sat_q;
  assign err       = err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_fir_stream_filter.sv
// Bench for fir_stream_filter: two instances (defaults; CHANNELS=3/SHIFT=12),
// table vectors, hand-written corner sequences and random traffic vs a reference model.
module tb_fir_stream_filter;

  localparam int TAPS = 8;
  localparam int RDY = 0, OV = 1, YO = 2, SAT = 3, OCH = 4, ERR = 5, BSY = 6;

  typedef struct {
    int op;
    int d;
    int ch;
    int v;
    int ey;
    bit es;
    bit ck;
  } vec_t;

  logic clk;
  logic rst [2];
  logic in_valid [2];
  logic [1:0] in_ch [2];
  logic [15:0] x_in [2];
  logic out_ready [2];
  logic coef_we [2];
  logic [2:0] coef_addr [2];
  logic [15:0] coef_data [2];

  wire rdy0, rdy1, ov0, ov1, sat0, sat1, er0, er1, bz0, bz1;
  wire oc0;
  wire [1:0] oc1;
  wire [19:0] y0, y1;

  int checks = 0;
  int errors = 0;
  int coef_m [2][TAPS];
  int hist_m [2][3][TAPS];
  vec_t tbl [$];

  fir_stream_filter dut0 (
    .clk(clk), .rst(rst[0]),
    .in_valid(in_valid[0]), .in_ready(rdy0),
    .in_ch(in_ch[0][0:0]), .x_in(x_in[0]),
    .out_valid(ov0), .out_ready(out_ready[0]),
    .out_ch(oc0), .y_out(y0), .y_sat(sat0),
    .coef_we(coef_we[0]), .coef_addr(coef_addr[0]),
    .coef_data(coef_data[0]),
    .err(er0), .busy(bz0)
  );

  fir_stream_filter #(.CHANNELS(3), .SHIFT(12)) dut1 (
    .clk(clk), .rst(rst[1]),
    .in_valid(in_valid[1]), .in_ready(rdy1),
    .in_ch(in_ch[1]), .x_in(x_in[1]),
    .out_valid(ov1), .out_ready(out_ready[1]),
    .out_ch(oc1), .y_out(y1), .y_sat(sat1),
    .coef_we(coef_we[1]), .coef_addr(coef_addr[1]),
    .coef_data(coef_data[1]),
    .err(er1), .busy(bz1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  function automatic longint o(input int d, input int s);
    case (s)
      RDY: return d != 0 ? longint'(rdy1) : longint'(rdy0);
      OV:  return d != 0 ? longint'(ov1) : longint'(ov0);
      YO:  return d != 0 ? longint'($signed(y1)) : longint'($signed(y0));
      SAT: return d != 0 ? longint'(sat1) : longint'(sat0);
      OCH: return d != 0 ? longint'(oc1) : longint'(oc0);
      ERR: return d != 0 ? longint'(er1) : longint'(er0);
      BSY: return d != 0 ? longint'(bz1) : longint'(bz0);
      default: return 0;
    endcase
  endfunction

  function automatic void chk(input string name, input longint act,
                              input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  function automatic int shv(input int d);
    return d != 0 ? 12 : 15;
  endfunction

  function automatic int nch(input int d);
    return d != 0 ? 3 : 2;
  endfunction

  function automatic void model_reset(input int d);
    for (int k = 0; k < TAPS; k++) begin
      coef_m[d][k] = (1 << shv(d)) / TAPS;
      for (int c = 0; c < 3; c++) hist_m[d][c][k] = 0;
    end
  endfunction

  function automatic void model_push(input int d, input int ch, input int x);
    for (int k = TAPS - 1; k > 0; k--) hist_m[d][ch][k] = hist_m[d][ch][k-1];
    hist_m[d][ch][0] = x;
  endfunction

  function automatic void model_eval(input int d, input int ch,
                                     output longint y, output bit s);
    longint acc;
    longint lim;
    acc = 0;
    for (int k = 0; k < TAPS; k++) begin
      acc += longint'(coef_m[d][k]) * longint'(hist_m[d][ch][k]);
    end
    y = (acc + (longint'(1) << (shv(d) - 1))) >>> shv(d);
    lim = longint'(1) << 19;
    s = 1'b0;
    if (y > lim - 1) begin
      y = lim - 1;
      s = 1'b1;
    end else if (y < -lim) begin
      y = -lim;
      s = 1'b1;
    end
  endfunction

  function automatic void add(input int op, input int d, input int ch,
                              input int v, input int ey, input bit es,
                              input bit ck);
    vec_t e;
    e.op = op; e.d = d; e.ch = ch; e.v = v;
    e.ey = ey; e.es = es; e.ck = ck;
    tbl.push_back(e);
  endfunction

  task automatic wcoef(input int d, input int a, input int v);
    coef_we[d] = 1'b1;
    coef_addr[d] = 3'(a);
    coef_data[d] = 16'(v);
    @(negedge clk);
    coef_we[d] = 1'b0;
    chk("coef_idle_err", o(d, ERR), 0);
    coef_m[d][a] = v;
  endtask

  task automatic do_reset(input int d);
    rst[d] = 1'b1;
    @(negedge clk);
    rst[d] = 1'b0;
    model_reset(d);
    @(negedge clk);
    chk("reset_ready", o(d, RDY), 1);
  endtask

  task automatic send(input int d, input int ch, input int x,
                      input bit cw, input int ca, input int cd,
                      input int hold, input bit poke,
                      output longint yo, output bit so);
    int lat;
    int bad;
    longint ey;
    bit es;
    longint ys;
    yo = 0;
    so = 1'b0;
    lat = 0;
    while (o(d, RDY) == 0 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("ready_wait", o(d, RDY), 1);
    in_valid[d] = 1'b1;
    in_ch[d] = 2'(ch);
    x_in[d] = 16'(x);
    if (cw) begin
      coef_we[d] = 1'b1;
      coef_addr[d] = 3'(ca);
      coef_data[d] = 16'(cd);
    end
    @(negedge clk);
    in_valid[d] = 1'b0;
    coef_we[d] = 1'b0;
    if (cw) coef_m[d][ca] = cd;
    if (ch >= nch(d)) begin
      chk("oor_err", o(d, ERR), 1);
      chk("oor_busy", o(d, BSY), 0);
      bad = 0;
      repeat (TAPS + 4) begin
        @(negedge clk);
        if (o(d, OV) != 0 || o(d, BSY) != 0) bad++;
      end
      chk("oor_quiet", bad, 0);
      chk("oor_err_clr", o(d, ERR), 0);
      return;
    end
    model_push(d, ch, x);
    model_eval(d, ch, ey, es);
    chk("busy", o(d, BSY), 1);
    lat = 0;
    while (o(d, OV) == 0 && lat < 50) begin
      if (poke && lat == 2) begin
        coef_we[d] = 1'b1;
        coef_addr[d] = 3'd0;
        coef_data[d] = 16'd0;
      end
      if (poke && lat == 3) begin
        coef_we[d] = 1'b0;
        chk("mac_we_err", o(d, ERR), 1);
      end
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, TAPS + 1);
    chk("y_out", o(d, YO), ey);
    chk("y_sat", o(d, SAT), longint'(es));
    chk("out_ch", o(d, OCH), ch);
    yo = o(d, YO);
    so = o(d, SAT) != 0;
    if (hold > 0) begin
      ys = o(d, YO);
      bad = 0;
      in_valid[d] = 1'b1;
      in_ch[d] = 2'd0;
      x_in[d] = 16'd123;
      repeat (hold) begin
        @(negedge clk);
        if (o(d, YO) != ys || o(d, RDY) != 0 || o(d, OV) != 1) bad++;
      end
      in_valid[d] = 1'b0;
      chk("hold_stable", bad, 0);
    end
    out_ready[d] = 1'b1;
    @(negedge clk);
    out_ready[d] = 1'b0;
    chk("out_drop", o(d, OV), 0);
    chk("idle_ready", o(d, RDY), 1);
  endtask

  initial begin
    longint yo;
    bit so;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1;
      in_valid[d] = 1'b0;
      in_ch[d] = '0;
      x_in[d] = '0;
      out_ready[d] = 1'b0;
      coef_we[d] = 1'b0;
      coef_addr[d] = '0;
      coef_data[d] = '0;
      model_reset(d);
    end

    for (int i = 0; i < 8; i++) add(0, 0, 0, 10000, 1250 * (i + 1), 0, 1);
    for (int i = 0; i < 8; i++) begin
      add(0, 0, 0, 10000, 10000, 0, 1);
      add(0, 0, 1, -200, -25 * (i + 1), 0, 1);
    end
    add(2, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) add(1, 0, k, 1000 * (k + 1), 0, 0, 0);
    add(0, 0, 0, 32767, 1000, 0, 1);
    for (int i = 1; i < 8; i++) add(0, 0, 0, 0, 1000 * (i + 1), 0, 1);
    for (int k = 0; k < 8; k++) add(1, 1, k, 32767, 0, 0, 0);
    for (int i = 0; i < 8; i++) add(0, 1, 0, 32767, 524287, 1, i == 7);
    for (int i = 0; i < 8; i++) add(0, 1, 0, -32768, -524288, 1, i == 7);

    repeat (2) @(negedge clk);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_in_ready", o(d, RDY), 1);
      chk("rst_out_valid", o(d, OV), 0);
      chk("rst_y_out", o(d, YO), 0);
      chk("rst_y_sat", o(d, SAT), 0);
      chk("rst_out_ch", o(d, OCH), 0);
      chk("rst_err", o(d, ERR), 0);
      chk("rst_busy", o(d, BSY), 0);
    end

    foreach (tbl[i]) begin
      case (tbl[i].op)
        0: begin
          send(tbl[i].d, tbl[i].ch, tbl[i].v, 1'b0, 0, 0, 0, 1'b0, yo, so);
          if (tbl[i].ck) begin
            chk($sformatf("tbl%0d_y", i), yo, tbl[i].ey);
            chk($sformatf("tbl%0d_sat", i), longint'(so), longint'(tbl[i].es));
          end
        end
        1: wcoef(tbl[i].d, tbl[i].ch, tbl[i].v);
        default: do_reset(tbl[i].d);
      endcase
    end

    // reset in the middle of a MAC run
    in_valid[0] = 1'b1;
    in_ch[0] = 2'd0;
    x_in[0] = 16'd10000;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst[0] = 1'b1;
    #1;
    chk("midrst_out_valid", o(0, OV), 0);
    chk("midrst_y_out", o(0, YO), 0);
    chk("midrst_busy", o(0, BSY), 0);
    chk("midrst_in_ready", o(0, RDY), 1);
    @(negedge clk);
    rst[0] = 1'b0;
    model_reset(0);
    @(negedge clk);
    send(0, 0, 10000, 1'b0, 0, 0, 0, 1'b0, yo, so);
    chk("restart_1250", yo, 1250);

    // coefficient write while the MAC is running must be dropped
    send(0, 0, 10000, 1'b0, 0, 0, 0, 1'b1, yo, so);
    send(0, 0, 10000, 1'b0, 0, 0, 0, 1'b0, yo, so);
    chk("coef_kept", yo, 3750);

    // backpressure, then a write landing with the accepted sample
    send(0, 1, -200, 1'b0, 0, 0, 20, 1'b0, yo, so);
    send(0, 1, 5000, 1'b1, 0, -8192, 0, 1'b0, yo, so);
    chk("same_cycle_coef", yo, -1275);

    // out-of-range channel on the three-channel instance
    send(1, 3, 1234, 1'b0, 0, 0, 0, 1'b0, yo, so);
    send(1, 2, 1000, 1'b0, 0, 0, 0, 1'b0, yo, so);

    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        wcoef(0, int'($urandom_range(0, 7)),
              int'($urandom_range(0, 65535)) - 32768);
      end
      send(0, int'($urandom_range(0, 1)),
           int'($urandom_range(0, 65535)) - 32768,
           $urandom_range(0, 3) == 0, int'($urandom_range(0, 7)),
           int'($urandom_range(0, 65535)) - 32768, 0, 1'b0, yo, so);
    end
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        wcoef(1, int'($urandom_range(0, 7)),
              int'($urandom_range(0, 65535)) - 32768);
      end
      send(1, int'($urandom_range(0, 3)),
           int'($urandom_range(0, 65535)) - 32768,
           $urandom_range(0, 3) == 0, int'($urandom_range(0, 7)),
           int'($urandom_range(0, 65535)) - 32768, 0, 1'b0, yo, so);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
